// File: rtl/master_spimemory_if.sv
// master_spimemory_if
// Bus bundle between a requester and the master_spimemory storage block.
//   wr_assert  : write request from the requester (1 = write in_instr, 0 = read)
//   in_instr   : 32-bit write data word
//   address    : 8-bit word address into the 256 x 32 array
//   check      : registered echo of wr_assert (write acknowledge)
//   out_instr  : registered data word (forwarded write data or stored word)
//   parity_err : read parity-mismatch flag (only with MASTER_SPIMEMORY_PARITY_EN)
// Modports: master = requester side, slave = storage side.
interface master_spimemory_if;
    logic        wr_assert;
    logic [31:0] in_instr;
    logic [7:0]  address;
    logic        check;
    logic [31:0] out_instr;
`ifdef MASTER_SPIMEMORY_PARITY_EN
    logic        parity_err;
`endif

`ifdef MASTER_SPIMEMORY_PARITY_EN
    modport master (output wr_assert, output in_instr, output address,
                    input check, input out_instr, input parity_err);
    modport slave  (input wr_assert, input in_instr, input address,
                    output check, output out_instr, output parity_err);
`else
    modport master (output wr_assert, output in_instr, output address,
                    input check, input out_instr);
    modport slave  (input wr_assert, input in_instr, input address,
                    output check, output out_instr);
`endif
endinterface

// File: rtl/master_spimemory.sv
// master_spimemory
// 256 x 32 word store with write-through forwarding and a one-cycle
// registered response. No state machine: every cycle is either a write
// (wr_assert high) or a read (wr_assert low).
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset; clears outputs and all 256 words
//   bus   : master_spimemory_if.slave (request in, check/out_instr out)
// Optional feature macro: MASTER_SPIMEMORY_PARITY_EN adds a per-word
// even-parity bit and the parity_err output on the interface.
module master_spimemory (
    input logic               clk,
    input logic               reset,
    master_spimemory_if.slave bus
);

    // Flop array rather than block RAM: every word must clear on reset.
    logic [31:0] mem_reg [256];
    logic        check_reg;
    logic [31:0] out_instr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            check_reg     <= 1'b0;
            out_instr_reg <= 32'd0;
            for (int i = 0; i < 256; i++) begin
                mem_reg[i] <= 32'd0;
            end
        end else begin
            check_reg <= bus.wr_assert;
            if (bus.wr_assert) begin
                // Write-through: the new word is forwarded, not the old one.
                mem_reg[bus.address] <= bus.in_instr;
                out_instr_reg        <= bus.in_instr;
            end else begin
                out_instr_reg <= mem_reg[bus.address];
            end
        end
    end

    assign bus.check     = check_reg;
    assign bus.out_instr = out_instr_reg;

`ifdef MASTER_SPIMEMORY_PARITY_EN
    // Even parity: stored bit equals XOR of the data bits, so a read whose
    // recomputed XOR differs from the stored bit indicates corruption.
    logic [255:0] par_reg;
    logic         parity_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_reg        <= '0;
            parity_err_reg <= 1'b0;
        end else begin
            if (bus.wr_assert) begin
                par_reg[bus.address] <= ^bus.in_instr;
                parity_err_reg       <= 1'b0;
            end else begin
                parity_err_reg <= (^mem_reg[bus.address]) != par_reg[bus.address];
            end
        end
    end

    assign bus.parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_master_spimemory.sv
// tb_master_spimemory
// Directed self-checking bench for master_spimemory. Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point, i.e. the
// response to the inputs applied before that edge.
module tb_master_spimemory;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    master_spimemory_if bus_if ();

    master_spimemory dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Apply one request, clock it, and check the registered response.
    task automatic xact(input string tag, input logic rst, input logic wr,
                        input logic [7:0] addr, input logic [31:0] din,
                        input logic exp_check, input logic [31:0] exp_out);
        reset            = rst;
        bus_if.wr_assert = wr;
        bus_if.address   = addr;
        bus_if.in_instr  = din;
        step();
        chk({tag, ".check"}, {31'd0, bus_if.check}, {31'd0, exp_check});
        chk({tag, ".out"}, bus_if.out_instr, exp_out);
`ifdef MASTER_SPIMEMORY_PARITY_EN
        chk({tag, ".perr"}, {31'd0, bus_if.parity_err}, 32'd0);
`endif
        $display("%s rst=%0b wr=%0b addr=%0d din=%h -> check=%0b out=%h",
                 tag, rst, wr, addr, din, bus_if.check, bus_if.out_instr);
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.wr_assert = 1'b0;
        bus_if.address   = 8'd0;
        bus_if.in_instr  = 32'd0;

        // Read after reset
        xact("reset", 1'b1, 1'b0, 8'd0, 32'd50000, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++)
            xact("rd_after_rst", 1'b0, 1'b0, 8'd0, 32'd50000, 1'b0, 32'd0);

        // Write then hold
        xact("wr_50000", 1'b0, 1'b1, 8'd0, 32'd50000, 1'b1, 32'd50000);
        for (int i = 0; i < 5; i++)
            xact("hold", 1'b0, 1'b0, 8'd0, 32'd10000, 1'b0, 32'd50000);

        // Overwrite
        xact("wr_10000", 1'b0, 1'b1, 8'd0, 32'd10000, 1'b1, 32'd10000);
        xact("rd_10000", 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 32'd10000);

        // Address isolation, including the top address
        xact("wr_a3", 1'b0, 1'b1, 8'd3, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5);
        xact("wr_a255", 1'b0, 1'b1, 8'd255, 32'h12345678, 1'b1, 32'h12345678);
        xact("rd_a3", 1'b0, 1'b0, 8'd3, 32'hFFFFFFFF, 1'b0, 32'hA5A5A5A5);
        xact("rd_a255", 1'b0, 1'b0, 8'd255, 32'hFFFFFFFF, 1'b0, 32'h12345678);
        xact("rd_a7", 1'b0, 1'b0, 8'd7, 32'hFFFFFFFF, 1'b0, 32'd0);
        xact("rd_a0", 1'b0, 1'b0, 8'd0, 32'hFFFFFFFF, 1'b0, 32'd10000);

        // Back-to-back writes to one address return the newest word
        xact("b2b_1", 1'b0, 1'b1, 8'd5, 32'h00000001, 1'b1, 32'h00000001);
        xact("b2b_2", 1'b0, 1'b1, 8'd5, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
        xact("b2b_rd", 1'b0, 1'b0, 8'd5, 32'd0, 1'b0, 32'hCAFEF00D);

        // Address switched together with a write: new address is used
        xact("wr_a9", 1'b0, 1'b1, 8'd9, 32'h0BADBEEF, 1'b1, 32'h0BADBEEF);
        xact("rd_a9", 1'b0, 1'b0, 8'd9, 32'd0, 1'b0, 32'h0BADBEEF);
        xact("rd_a5_kept", 1'b0, 1'b0, 8'd5, 32'd0, 1'b0, 32'hCAFEF00D);

        // Reset during a write: write dropped, storage cleared
        xact("rst_wr", 1'b1, 1'b1, 8'd0, 32'hDEADDEAD, 1'b0, 32'd0);
        xact("rd_a0_cleared", 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
        xact("rd_a3_cleared", 1'b0, 1'b0, 8'd3, 32'd0, 1'b0, 32'd0);
        xact("rd_a255_cleared", 1'b0, 1'b0, 8'd255, 32'd0, 1'b0, 32'd0);

        // Normal operation on the first edge after reset falls
        xact("wr_after_rst", 1'b0, 1'b1, 8'd128, 32'h80000001, 1'b1, 32'h80000001);
        xact("rd_after_wr", 1'b0, 1'b0, 8'd128, 32'd0, 1'b0, 32'h80000001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
